// File: rtl/pingpong_score_display_if.sv
// Score/display bundle between the game core, the scoring block and the
// display pins: point pulses and clear in, segment/digit drive and result out.
interface pingpong_score_display_if;
  logic       POINT_L;
  logic       POINT_R;
  logic       CLR_SCORE;
  logic [7:0] SEG7_SCORE;
  logic [7:0] WHICH_LIGHT;
  logic       GAME_OVER;
  logic       WINNER;

  // Upstream side: issues points/clear, observes the display and result.
  modport master (
    output POINT_L, POINT_R, CLR_SCORE,
    input  SEG7_SCORE, WHICH_LIGHT, GAME_OVER, WINNER
  );

  // Score/display block side.
  modport slave (
    input  POINT_L, POINT_R, CLR_SCORE,
    output SEG7_SCORE, WHICH_LIGHT, GAME_OVER, WINNER
  );
endinterface

// File: rtl/pingpong_score_display.sv
// Two-player BCD scorekeeper with win detection, driving a 4-digit scanned
// 7-segment display (right units, right tens, left units, left tens).
module pingpong_score_display #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned WIN_SCORE = 11
) (
  input logic                     CLK,
  input logic                     RST,
  pingpong_score_display_if.slave bus
);

  localparam int unsigned    CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [7:0]     WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  logic [7:0]    score_l;
  logic [7:0]    score_r;
  logic          game_over;
  logic          winner;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig_idx;
  logic [7:0]    seg_q;
  logic [7:0]    light_q;

  logic          win_l;
  logic          win_r;
  logic          cnt_wrap;
  logic [1:0]    idx_nxt;
  logic [3:0]    digit;
  logic          blank;
  logic          dp;
  logic [7:0]    seg_nxt;
  logic [7:0]    light_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Win detection, scan sequencing and the segment pattern for the next slot.
  always_comb begin
    win_l    = (score_l == WIN_BCD);
    win_r    = (score_r == WIN_BCD);
    cnt_wrap = (scan_cnt == CNT_MAX);
    idx_nxt  = cnt_wrap ? dig_idx + 2'd1 : dig_idx;
    digit    = score_r[3:0];
    blank    = 1'b0;
    dp       = 1'b0;
    case (idx_nxt)
      2'd0: begin
        digit = score_r[3:0];
        dp    = game_over & winner;
      end
      2'd1: begin
        digit = score_r[7:4];
        blank = (score_r[7:4] == 4'd0);
      end
      2'd2: begin
        digit = score_l[3:0];
        dp    = game_over & ~winner;
      end
      default: begin
        digit = score_l[7:4];
        blank = (score_l[7:4] == 4'd0);
      end
    endcase
    seg_nxt   = {dp, blank ? 7'h00 : seg_code(digit)};
    light_nxt = {4'hF, ~(4'b0001 << idx_nxt)};
  end

  // Scores and game result; the result latches once and freezes scoring.
  always_ff @(posedge CLK) begin
    if (RST || bus.CLR_SCORE) begin
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (!game_over) begin
      if (bus.POINT_L) score_l <= bcd_inc(score_l);
      if (bus.POINT_R) score_r <= bcd_inc(score_r);
      if (win_l || win_r) begin
        game_over <= 1'b1;
        winner    <= ~win_l;
      end
    end
  end

  // Digit scan and registered display drive; clear leaves the scan running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      seg_q    <= 8'h3F;
      light_q  <= 8'hFE;
    end else begin
      scan_cnt <= cnt_wrap ? '0 : scan_cnt + 1'b1;
      dig_idx  <= idx_nxt;
      seg_q    <= seg_nxt;
      light_q  <= light_nxt;
    end
  end

  assign bus.SEG7_SCORE  = seg_q;
  assign bus.WHICH_LIGHT = light_q;
  assign bus.GAME_OVER   = game_over;
  assign bus.WINNER      = winner;

endmodule

// File: tb/tb_pingpong_score_display.sv
// Directed bench for pingpong_score_display with a 4-cycle digit slot.
module tb_pingpong_score_display;

  logic CLK;
  logic RST;
  int unsigned cyc;
  int unsigned passed;
  int unsigned total;
  int unsigned failed;

  pingpong_score_display_if bus ();

  pingpong_score_display #(.SCAN_DIV(4), .WIN_SCORE(11)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance to scan slot 'slot', count 'sub' (16-cycle scan period), then
  // confirm the digit select there.
  task automatic go_to(input int unsigned slot, input int unsigned sub);
    int unsigned target;
    logic [3:0] sel;
    target = slot * 4 + sub;
    for (int i = 0; i < 16 && (cyc % 16) != target; i++) step();
    sel = ~(4'b0001 << slot);
    chk("scan_light", bus.WHICH_LIGHT, {4'hF, sel});
  endtask

  initial begin
    cyc = 0; passed = 0; total = 0; failed = 0;
    RST = 1'b1;
    bus.POINT_L = 1'b0;
    bus.POINT_R = 1'b0;
    bus.CLR_SCORE = 1'b0;

    // Reset
    step(); step(); step();
    chk("rst_light", bus.WHICH_LIGHT, 8'hFE);
    chk("rst_seg",   bus.SEG7_SCORE,  8'h3F);
    chk("rst_go",    {7'd0, bus.GAME_OVER}, 8'h00);
    chk("rst_win",   {7'd0, bus.WINNER},    8'h00);
    RST = 1'b0;
    cyc = 0;

    // Scan walk
    chk("t1_light0", bus.WHICH_LIGHT, 8'hFE);
    step(); step(); step();
    chk("t1_light3", bus.WHICH_LIGHT, 8'hFE);
    step();
    chk("t1_light4", bus.WHICH_LIGHT, 8'hFD);
    chk("t1_seg4",   bus.SEG7_SCORE,  8'h00);
    go_to(2, 0); chk("t1_seg_i2", bus.SEG7_SCORE, 8'h3F);
    go_to(3, 0); chk("t1_seg_i3", bus.SEG7_SCORE, 8'h00);
    go_to(0, 0); chk("t1_seg_i0", bus.SEG7_SCORE, 8'h3F);

    // Ten left points -> L=10
    repeat (10) begin
      bus.POINT_L = 1'b1; step();
      bus.POINT_L = 1'b0; step();
    end
    go_to(0, 1); chk("t2_i0", bus.SEG7_SCORE, 8'h3F);
    go_to(1, 1); chk("t2_i1", bus.SEG7_SCORE, 8'h00);
    go_to(2, 1); chk("t2_i2", bus.SEG7_SCORE, 8'h3F);
    go_to(3, 1); chk("t2_i3", bus.SEG7_SCORE, 8'h06);

    // Clear, then 9/9 with points held in both lanes
    bus.CLR_SCORE = 1'b1; step(); bus.CLR_SCORE = 1'b0;
    chk("t3_clr_go", {7'd0, bus.GAME_OVER}, 8'h00);
    bus.POINT_L = 1'b1; bus.POINT_R = 1'b1;
    repeat (9) step();
    bus.POINT_L = 1'b0; bus.POINT_R = 1'b0;
    go_to(0, 1); chk("t3_99_i0", bus.SEG7_SCORE, 8'h6F);
    go_to(1, 1); chk("t3_99_i1", bus.SEG7_SCORE, 8'h00);
    go_to(2, 1); chk("t3_99_i2", bus.SEG7_SCORE, 8'h6F);
    go_to(3, 1); chk("t3_99_i3", bus.SEG7_SCORE, 8'h00);
    // Simultaneous point carries both into tens -> 10/10
    bus.POINT_L = 1'b1; bus.POINT_R = 1'b1; step();
    bus.POINT_L = 1'b0; bus.POINT_R = 1'b0;
    go_to(0, 1); chk("t3_1010_i0", bus.SEG7_SCORE, 8'h3F);
    go_to(1, 1); chk("t3_1010_i1", bus.SEG7_SCORE, 8'h06);
    go_to(2, 1); chk("t3_1010_i2", bus.SEG7_SCORE, 8'h3F);
    go_to(3, 1); chk("t3_1010_i3", bus.SEG7_SCORE, 8'h06);
    // Right reaches 11: game over one edge later
    bus.POINT_R = 1'b1; step(); bus.POINT_R = 1'b0;
    chk("t3_go_lag", {7'd0, bus.GAME_OVER}, 8'h00);
    step();
    chk("t3_go",  {7'd0, bus.GAME_OVER}, 8'h01);
    chk("t3_win", {7'd0, bus.WINNER},    8'h01);
    step();
    go_to(0, 1); chk("t3_dp_i0", bus.SEG7_SCORE, 8'h86);
    go_to(1, 1); chk("t3_i1",    bus.SEG7_SCORE, 8'h06);
    go_to(2, 1); chk("t3_i2",    bus.SEG7_SCORE, 8'h3F);

    // Points ignored after game over
    bus.POINT_L = 1'b1; repeat (5) step(); bus.POINT_L = 1'b0;
    chk("t4_go",  {7'd0, bus.GAME_OVER}, 8'h01);
    chk("t4_win", {7'd0, bus.WINNER},    8'h01);
    go_to(2, 1); chk("t4_i2", bus.SEG7_SCORE, 8'h3F);
    go_to(3, 1); chk("t4_i3", bus.SEG7_SCORE, 8'h06);

    // Both reach 11 on the same edge: left wins
    bus.CLR_SCORE = 1'b1; step(); bus.CLR_SCORE = 1'b0;
    bus.POINT_L = 1'b1; bus.POINT_R = 1'b1;
    repeat (11) step();
    bus.POINT_L = 1'b0; bus.POINT_R = 1'b0;
    chk("tie_go_lag", {7'd0, bus.GAME_OVER}, 8'h00);
    step();
    chk("tie_go",  {7'd0, bus.GAME_OVER}, 8'h01);
    chk("tie_win", {7'd0, bus.WINNER},    8'h00);
    step();
    go_to(2, 1); chk("tie_dp_i2", bus.SEG7_SCORE, 8'h86);
    go_to(0, 1); chk("tie_i0",    bus.SEG7_SCORE, 8'h06);
    go_to(1, 1); chk("tie_i1",    bus.SEG7_SCORE, 8'h06);

    // Clear beats a same-cycle point; scan keeps going
    go_to(2, 2);
    bus.CLR_SCORE = 1'b1; bus.POINT_R = 1'b1; step();
    bus.CLR_SCORE = 1'b0; bus.POINT_R = 1'b0;
    chk("t5_go",    {7'd0, bus.GAME_OVER}, 8'h00);
    chk("t5_win",   {7'd0, bus.WINNER},    8'h00);
    chk("t5_light", bus.WHICH_LIGHT, 8'hFB);
    step();
    go_to(0, 1); chk("t5_i0", bus.SEG7_SCORE, 8'h3F);
    go_to(1, 1); chk("t5_i1", bus.SEG7_SCORE, 8'h00);
    go_to(2, 1); chk("t5_i2", bus.SEG7_SCORE, 8'h3F);
    go_to(3, 1); chk("t5_i3", bus.SEG7_SCORE, 8'h00);

    // Reset mid-scan at count 2 of index 3
    bus.POINT_L = 1'b1; step(); bus.POINT_L = 1'b0;
    go_to(2, 1); chk("t6_pre_i2", bus.SEG7_SCORE, 8'h06);
    go_to(3, 2);
    RST = 1'b1; step(); RST = 1'b0;
    cyc = 0;
    chk("t6_light", bus.WHICH_LIGHT, 8'hFE);
    chk("t6_seg",   bus.SEG7_SCORE,  8'h3F);
    chk("t6_go",    {7'd0, bus.GAME_OVER}, 8'h00);
    step(); step(); step();
    chk("t6_light3", bus.WHICH_LIGHT, 8'hFE);
    go_to(1, 0); chk("t6_i1", bus.SEG7_SCORE, 8'h00);
    go_to(2, 1); chk("t6_i2", bus.SEG7_SCORE, 8'h3F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
